reg_file: RTL and testbench

- 32 x 32-bit MIPS general-purpose register file, directly upstream of the ALU in the single-cycle datapath.
- Two combinational read ports: rd1 drives ALU operand A; rd2 drives operand B, or the data-memory write data when ALUSrc selects the immediate.
- One synchronous write port, fed by the ALU-result/memory-read writeback mux.
- Register $0 is hardwired to zero; $sp and $gp take conventional reset values.

---
 rtl/reg_file.sv | 56 +++++
 tb/tb_reg_file.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// 32 x WIDTH MIPS general-purpose register file.
// Two combinational read ports plus a debug read port, one synchronous write port.
// $0 reads as zero; $gp and $sp come out of reset at their conventional values.
module reg_file #(
  parameter int unsigned         WIDTH   = 32,
  parameter logic [WIDTH-1:0]    SP_INIT = 32'h7FFF_FFFC,
  parameter logic [WIDTH-1:0]    GP_INIT = 32'h1000_8000,
  parameter bit                  BYPASS  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we3,
  input  logic [4:0]       a1,
  input  logic [4:0]       a2,
  input  logic [4:0]       a3,
  input  logic [WIDTH-1:0] wd3,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  input  logic [4:0]       dbg_a,
  output logic [WIDTH-1:0] dbg_d
);

  localparam logic [4:0] GP_IDX = 5'd28;
  localparam logic [4:0] SP_IDX = 5'd29;

  logic [WIDTH-1:0] regs [32];
  logic             wr_en;
  logic             fwd_en;

  // A write only lands when enabled, out of reset, and not aimed at $0.
  always_comb begin
    wr_en  = we3 && rst_n && (a3 != '0);
    fwd_en = BYPASS && wr_en;
  end

  // Register array: asynchronous clear to conventional values, rising-edge write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
      regs[GP_IDX] <= GP_INIT;
      regs[SP_IDX] <= SP_INIT;
    end else if (wr_en) begin
      regs[a3] <= wd3;
    end
  end

  // Read ports: $0 forced to zero, optional write-first forwarding of wd3.
  always_comb begin
    rd1   = (a1 == '0)    ? '0 : (fwd_en && a1 == a3)    ? wd3 : regs[a1];
    rd2   = (a2 == '0)    ? '0 : (fwd_en && a2 == a3)    ? wd3 : regs[a2];
    dbg_d = (dbg_a == '0) ? '0 : (fwd_en && dbg_a == a3) ? wd3 : regs[dbg_a];
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: one read-first and one write-first instance
// share the same stimulus and are compared against vector tables and a model.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we3;
  logic [4:0]  a1, a2, a3, dbg_a;
  logic [31:0] wd3;
  logic [31:0] rd1_0, rd2_0, dbg_0;
  logic [31:0] rd1_1, rd2_1, dbg_1;

  int tests  = 0;
  int failed = 0;

  logic [31:0] model [32];

  always #5 clk = ~clk;

  reg_file #(.WIDTH(32), .SP_INIT(32'h7FFF_FFFC), .GP_INIT(32'h1000_8000), .BYPASS(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .we3(we3), .a1(a1), .a2(a2), .a3(a3), .wd3(wd3),
    .rd1(rd1_0), .rd2(rd2_0), .dbg_a(dbg_a), .dbg_d(dbg_0)
  );

  reg_file #(.WIDTH(32), .SP_INIT(32'h7FFF_FFFC), .GP_INIT(32'h1000_8000), .BYPASS(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .we3(we3), .a1(a1), .a2(a2), .a3(a3), .wd3(wd3),
    .rd1(rd1_1), .rd2(rd2_1), .dbg_a(dbg_a), .dbg_d(dbg_1)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] pre1_rf;   // before the edge, read-first
    logic [31:0] pre2_rf;
    logic [31:0] pre1_wf;   // before the edge, write-first
    logic [31:0] pre2_wf;
    logic [31:0] post1;     // after the edge, both modes
    logic [31:0] post2;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    model[28] = 32'h1000_8000;
    model[29] = 32'h7FFF_FFFC;
  endtask

  // Architectural view: what a port at address a should show right now.
  function automatic logic [31:0] expect_rd(input logic [4:0] a, input bit write_first);
    if (a == 5'd0) return 32'h0;
    if (write_first && rst_n && we3 && a3 != 5'd0 && a == a3) return wd3;
    return model[a];
  endfunction

  task automatic model_edge();
    if (rst_n && we3 && a3 != 5'd0) model[a3] = wd3;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra1, input logic [4:0] ra2, input logic [4:0] da);
    we3 = we; a3 = wa; wd3 = wd; a1 = ra1; a2 = ra2; dbg_a = da;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Plain reset values.
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd29, 5'd28, 5'd0);
    #1;
    chk("reset_sp_rf", rd1_0, 32'h7FFF_FFFC);
    chk("reset_gp_rf", rd2_0, 32'h1000_8000);
    chk("reset_r0_wf", dbg_1, 32'h0);

    // Put something in reg5 so the reset clear is observable.
    drive(1'b1, 5'd5, 32'h1111_2222, 5'd29, 5'd28, 5'd5);
    @(posedge clk); model_edge(); #1;
    chk("pre_reset_r5", dbg_0, 32'h1111_2222);

    // Mid-cycle asynchronous reset with a write pending.
    @(negedge clk);
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd29, 5'd28, 5'd5);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_sp_rf", rd1_0, 32'h7FFF_FFFC);
    chk("async_rst_gp_rf", rd2_0, 32'h1000_8000);
    chk("async_rst_r5_rf", dbg_0, 32'h0);
    chk("async_rst_sp_wf", rd1_1, 32'h7FFF_FFFC);
    chk("async_rst_r5_wf", dbg_1, 32'h0);
    @(posedge clk); #1;
    chk("rst_blocks_wr_rf", dbg_0, 32'h0);
    chk("rst_blocks_wr_wf", dbg_1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 5'd5, 32'hDEAD_BEEF, 5'd29, 5'd28, 5'd5);
    @(posedge clk); #1;
    chk("after_rel_r5_rf", dbg_0, 32'h0);
    chk("after_rel_r5_wf", dbg_1, 32'h0);

    // Vector table; starts from the reset state.
    vecs[0] = '{1'b1, 5'd8,  32'h0000_0007, 5'd8,  5'd9,  32'h0, 32'h0, 32'h7, 32'h0, 32'h7, 32'h0};
    vecs[1] = '{1'b1, 5'd9,  32'hFFFF_FFF9, 5'd8,  5'd9,  32'h7, 32'h0, 32'h7, 32'hFFFF_FFF9, 32'h7, 32'hFFFF_FFF9};
    vecs[2] = '{1'b1, 5'd0,  32'h1234_5678, 5'd0,  5'd0,  32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[3] = '{1'b1, 5'd10, 32'h0000_0001, 5'd10, 5'd29, 32'h0, 32'h7FFF_FFFC, 32'h1, 32'h7FFF_FFFC, 32'h1, 32'h7FFF_FFFC};
    vecs[4] = '{1'b1, 5'd10, 32'h0000_0002, 5'd10, 5'd10, 32'h1, 32'h1, 32'h2, 32'h2, 32'h2, 32'h2};
    vecs[5] = '{1'b0, 5'd11, 32'hFFFF_FFFF, 5'd11, 5'd11, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[6] = '{1'b1, 5'd29, 32'hABCD_0000, 5'd29, 5'd28, 32'h7FFF_FFFC, 32'h1000_8000, 32'hABCD_0000, 32'h1000_8000, 32'hABCD_0000, 32'h1000_8000};
    vecs[7] = '{1'b1, 5'd28, 32'h0000_0055, 5'd28, 5'd8,  32'h1000_8000, 32'h7, 32'h55, 32'h7, 32'h55, 32'h7};

    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      drive(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].ra1, vecs[v].ra2, vecs[v].ra1);
      #1;
      chk($sformatf("v%0d_pre_rd1_rf", v), rd1_0, vecs[v].pre1_rf);
      chk($sformatf("v%0d_pre_rd2_rf", v), rd2_0, vecs[v].pre2_rf);
      chk($sformatf("v%0d_pre_rd1_wf", v), rd1_1, vecs[v].pre1_wf);
      chk($sformatf("v%0d_pre_rd2_wf", v), rd2_1, vecs[v].pre2_wf);
      chk($sformatf("v%0d_pre_dbg_wf", v), dbg_1, vecs[v].pre1_wf);
      @(posedge clk); model_edge(); #1;
      chk($sformatf("v%0d_post_rd1_rf", v), rd1_0, vecs[v].post1);
      chk($sformatf("v%0d_post_rd2_rf", v), rd2_0, vecs[v].post2);
      chk($sformatf("v%0d_post_rd1_wf", v), rd1_1, vecs[v].post1);
      chk($sformatf("v%0d_post_rd2_wf", v), rd2_1, vecs[v].post2);
      if (v == 1) begin
        // ALU SUB of 7 and -7 is nonzero, so zero flag is 0.
        chk("sub_zero_flag", {31'h0, (rd1_0 - rd2_0) == 32'h0}, 32'h0);
      end
    end

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      drive(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
            ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom),
            5'($urandom), 5'($urandom));
      if ($urandom_range(0, 4) == 0) a1 = a3;
      if ($urandom_range(0, 4) == 0) a2 = a1;
      #1;
      chk("rnd_rd1_rf", rd1_0, expect_rd(a1, 1'b0));
      chk("rnd_rd2_rf", rd2_0, expect_rd(a2, 1'b0));
      chk("rnd_dbg_rf", dbg_0, expect_rd(dbg_a, 1'b0));
      chk("rnd_rd1_wf", rd1_1, expect_rd(a1, 1'b1));
      chk("rnd_rd2_wf", rd2_1, expect_rd(a2, 1'b1));
      chk("rnd_dbg_wf", dbg_1, expect_rd(dbg_a, 1'b1));
      @(posedge clk); model_edge();
    end

    // Full sweep: fill every register, then read back through all ports.
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      drive(1'b1, 5'(i), 32'(i) * 32'h0101_0101, 5'd0, 5'd0, 5'd0);
      @(posedge clk); model_edge();
    end
    for (int i = 0; i < 32; i++) begin
      logic [31:0] exp;
      exp = (i == 0) ? 32'h0 : 32'(i) * 32'h0101_0101;
      @(negedge clk);
      drive(1'b0, 5'(i), 32'hFFFF_FFFF, 5'(i), 5'(i), 5'(i));
      #1;
      chk($sformatf("sweep%0d_rd1_rf", i), rd1_0, exp);
      chk($sformatf("sweep%0d_rd2_rf", i), rd2_0, exp);
      chk($sformatf("sweep%0d_dbg_rf", i), dbg_0, exp);
      chk($sformatf("sweep%0d_rd1_wf", i), rd1_1, exp);
      chk($sformatf("sweep%0d_rd2_wf", i), rd2_1, exp);
      chk($sformatf("sweep%0d_dbg_wf", i), dbg_1, exp);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
